// File: rtl/ifu_axil_master_if.sv
// AXI-lite bus between the instruction-fetch master and the instruction SRAM slave.
// The write channels are carried only so that the master can tie them off.
interface ifu_axil_master_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/ifu_axil_master.sv
// Instruction-fetch AXI-lite master: one AR/R per instruction, valid/ready to decode, PC redirects.
// Define IFU_PERF_CNT_EN to build the fetch/stall performance counters.
module ifu_axil_master #(
   parameter int unsigned           ADDR_W   = 32,
   parameter int unsigned           DATA_W   = 32,
   parameter logic [ADDR_W-1:0]     RESET_PC = 32'h8000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   ifu_axil_master_if.master    bus,
   output logic [DATA_W-1:0]    inst,
   output logic [ADDR_W-1:0]    inst_pc,
   output logic                 inst_err,
   output logic                 inst_valid,
   input  logic                 inst_ready,
   input  logic                 redirect_valid,
   input  logic [ADDR_W-1:0]    redirect_pc,
   output logic [31:0]          perf_fetch_cnt,
   output logic [31:0]          perf_stall_cnt
);

   typedef enum logic [1:0] {StIdle, StAr, StR, StOut} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic                redir_pend_q, redir_pend_d;
   logic [ADDR_W-1:0]   redir_pc_q, redir_pc_d;
   logic [DATA_W-1:0]   inst_q, inst_d;
   logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
   logic                inst_err_q, inst_err_d;
   logic [ADDR_W-1:0]   redirect_tgt;
   logic                fetch_inc;

   assign redirect_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      redir_pend_d = redir_pend_q;
      redir_pc_d   = redir_pc_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_err_d   = inst_err_q;
      fetch_inc    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (redirect_valid) pc_d = redirect_tgt;
            redir_pend_d = 1'b0;
            state_d      = StAr;
         end
         StAr: begin
            if (redirect_valid) begin
               redir_pend_d = 1'b1;
               redir_pc_d   = redirect_tgt;
            end
            if (bus.arready) state_d = StR;
         end
         StR: begin
            if (redirect_valid) begin
               redir_pend_d = 1'b1;
               redir_pc_d   = redirect_tgt;
            end
            if (bus.rvalid) begin
               // A redirect arriving with the beat still discards it; the newest target wins.
               if (redirect_valid || redir_pend_q) begin
                  pc_d         = redirect_valid ? redirect_tgt : redir_pc_q;
                  redir_pend_d = 1'b0;
                  state_d      = StAr;
               end else begin
                  inst_d     = bus.rdata;
                  inst_err_d = (bus.rresp != 2'b00);
                  inst_pc_d  = pc_q;
                  state_d    = StOut;
               end
            end
         end
         StOut: begin
            if (redirect_valid) begin
               pc_d         = redirect_tgt;
               redir_pend_d = 1'b0;
               state_d      = StAr;
            end else if (inst_ready) begin
               pc_d         = pc_q + ADDR_W'(4);
               redir_pend_d = 1'b0;
               fetch_inc    = 1'b1;
               state_d      = StAr;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         pc_q         <= RESET_PC;
         redir_pend_q <= 1'b0;
         redir_pc_q   <= '0;
         inst_q       <= DATA_W'(32'h0000_0013);
         inst_pc_q    <= RESET_PC;
         inst_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         redir_pend_q <= redir_pend_d;
         redir_pc_q   <= redir_pc_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         inst_err_q   <= inst_err_d;
      end
   end

   assign bus.araddr  = pc_q;
   assign bus.arvalid = (state_q == StAr);
   assign bus.rready  = (state_q == StR);
   assign bus.awaddr  = '0;
   assign bus.awvalid = 1'b0;
   assign bus.wdata   = '0;
   assign bus.wstrb   = '0;
   assign bus.wvalid  = 1'b0;
   assign bus.bready  = 1'b0;

   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign inst_err   = inst_err_q;
   assign inst_valid = (state_q == StOut);

`ifdef IFU_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q + 32'(fetch_inc);
      stall_cnt_d = stall_cnt_q + 32'((state_q == StAr) || (state_q == StR));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`else
   logic unused_fetch_inc;
   assign unused_fetch_inc = fetch_inc;
   assign perf_fetch_cnt   = 32'h0;
   assign perf_stall_cnt   = 32'h0;
`endif

   logic unused_inputs;
   assign unused_inputs = ^{bus.awready, bus.wready, bus.bresp, bus.bvalid, redirect_pc[1:0]};

endmodule
